// File: rtl/bcd_to_binary_seq.sv
// Multi-cycle BCD-to-binary converter (reverse double-dabble: shift right, subtract 3).
// One operand in flight; valid/ready on both sides; digits > 9 are flagged instead of converted.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      binary_out,
  output logic                  bcd_error,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state_reg, state_next;
  logic [BCD_W-1:0]   bcd_reg, bcd_next, bcd_shift, bcd_adj;
  logic [BIN_W-1:0]   bin_reg, bin_next, bin_shift;
  logic [BIN_W-1:0]   out_reg, out_next;
  logic               err_reg, err_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [DIGITS-1:0]  digit_bad;

  // The BCD LSB falls into the binary MSB on every iteration.
  assign {bcd_shift, bin_shift} = {bcd_reg, bin_reg} >> 1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = (bcd_shift[4*gi +: 4] >= 4'd8) ?
                                  (bcd_shift[4*gi +: 4] - 4'd3) : bcd_shift[4*gi +: 4];
      assign digit_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      out_reg   <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      bcd_reg   <= bcd_next;
      bin_reg   <= bin_next;
      out_reg   <= out_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bcd_next   = bcd_reg;
    bin_next   = bin_reg;
    out_next   = out_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (|digit_bad) begin
            out_next   = '0;
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            bcd_next   = bcd_in;
            bin_next   = '0;
            cnt_next   = '0;
            state_next = CONV;
          end
        end
      end
      CONV: begin
        bcd_next = bcd_adj;
        bin_next = bin_shift;
        cnt_next = cnt_reg + CNT_W'(1);
        // The last iteration's shifted value goes straight to the output register.
        if (cnt_reg == CNT_W'(BIN_W - 1)) begin
          out_next   = bin_shift;
          err_next   = 1'b0;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign binary_out = out_reg;
  assign bcd_error  = err_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Bench for bcd_to_binary_seq: arithmetic reference model checked every cycle, plus
// directed vectors with literal expected values and latencies.
module tb_bcd_to_binary_seq;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd_in = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, bcd_error;
  logic [9:0]  binary_out;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready),
    .binary_out(binary_out), .bcd_error(bcd_error), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int bcd_value(input logic [11:0] b);
    int v = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v += int'(b[4*i +: 4]) * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic bit bcd_bad(input logic [11:0] b);
    bit bad = 0;
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) bad = 1;
    return bad;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: busy from accept to result handshake, result appears BIN_W edges
  // after accept (same edge for a rejected operand).
  bit m_live = 0, m_busy = 0, m_valid = 0, m_err = 0;
  int m_left = 0, m_val = 0, m_last = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_live <= 1; m_busy <= 0; m_valid <= 0; m_last <= 0; m_err <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1;
        if (bcd_bad(bcd_in)) begin
          m_err <= 1; m_val <= 0; m_valid <= 1; m_last <= 0;
        end else begin
          m_err <= 0; m_val <= bcd_value(bcd_in); m_left <= BIN_W;
        end
      end
    end else if (!m_valid) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1; m_last <= m_val;
      end
    end else if (out_ready) begin
      m_busy <= 0; m_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_in_ready", int'(in_ready), int'(!m_busy));
      check("model_out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        check("model_binary_out", int'(binary_out), m_val);
        check("model_bcd_error", int'(bcd_error), int'(m_err));
      end else begin
        check("model_binary_out_held", int'(binary_out), m_last);
      end
    end
  end

  // One transaction: present operand, wait for accept, measure edges to out_valid,
  // optionally stall the result for `hold` cycles with in_valid kept high.
  task automatic conv(input logic [11:0] b, input int exp_val, input int exp_err,
                      input int exp_lat, input int hold);
    int k = 0;
    bcd_in = b;
    in_valid = 1'b1;
    if (hold > 0) out_ready = 1'b0;
    @(negedge clk);
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0; out_ready = 1'b1;
      return;
    end
    @(posedge clk); #1;
    if (hold == 0) in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 40) begin k++; @(negedge clk); end
    check("latency", k, exp_lat);
    check("binary_out", int'(binary_out), exp_val);
    check("bcd_error", int'(bcd_error), exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_binary_out", int'(binary_out), exp_val);
      check("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    $display("bcd=%03h -> binary=%0d err=%0d latency=%0d hold=%0d", b, exp_val, exp_err, exp_lat, hold);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_binary_out", int'(binary_out), 0);
    check("reset_bcd_error", int'(bcd_error), 0);
    @(posedge clk); #1;

    conv(12'h255, 255, 0, 10, 0);
    conv(12'h999, 999, 0, 10, 0);
    conv(12'h000, 0, 0, 10, 0);
    conv(12'h1A3, 0, 1, 0, 0);
    conv(12'h468, 468, 0, 10, 6);
    conv(12'h90F, 0, 1, 0, 0);
    conv(12'h807, 807, 0, 10, 0);

    // Abort a conversion with reset on its 4th CONV cycle.
    bcd_in = 12'h123;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_binary_out", int'(binary_out), 0);
    $display("reset during conversion of bcd=123 -> idle, binary=0");
    @(posedge clk); #1;
    conv(12'h042, 42, 0, 10, 0);

    for (int v = 0; v < 256; v++) conv(to_bcd(v), v, 0, 10, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
